// File: rtl/dpll_nco_tracker_if.sv
// Reference/control inputs and recovered-clock status outputs of the NCO tracker.
interface dpll_nco_tracker_if #(
  parameter int ACC_W = 16
);
  logic             RefIn;
  logic             Hold;
  logic             ClockOut;
  logic             CarryOut;
  logic             Locked;
  logic             Holdover;
  logic [ACC_W-1:0] FreqWord;

  modport master (
    output RefIn, Hold,
    input  ClockOut, CarryOut, Locked, Holdover, FreqWord
  );

  modport slave (
    input  RefIn, Hold,
    output ClockOut, CarryOut, Locked, Holdover, FreqWord
  );
endinterface

// File: rtl/dpll_nco_tracker.sv
// All-digital PLL: NCO at MULT x RefIn, PI loop filter on sampled phase error,
// lock detection, Hold freeze and automatic holdover on reference loss.
module dpll_nco_tracker #(
  parameter int ACC_W       = 16,
  parameter int MULT        = 32,
  parameter int NOMINAL_INC = 2048,
  parameter int KP_SHIFT    = 2,
  parameter int KI_SHIFT    = 6,
  parameter int LOCK_TOL    = 4096,
  parameter int LOCK_COUNT  = 8
) (
  input logic               Clock,
  input logic               Reset,
  dpll_nco_tracker_if.slave bus
);
  localparam int DIV_W = $clog2(MULT);
  localparam int PH_W  = DIV_W + ACC_W;
  localparam int W     = PH_W + 2;
  localparam int LC_W  = $clog2(LOCK_COUNT + 1);

  localparam logic signed [W-1:0] NOM_W     = W'(NOMINAL_INC);
  localparam logic signed [W-1:0] INTEG_LIM = W'(2 ** (ACC_W - 2));
  localparam logic signed [W-1:0] INC_MAX   = W'(2 ** (ACC_W - 1) - 1);
  localparam logic signed [W-1:0] INC_MIN   = W'(1);
  localparam logic signed [W-1:0] TOL_W     = W'(LOCK_TOL);
  localparam logic [LC_W-1:0]     LOCK_FULL = LC_W'(LOCK_COUNT);
  localparam logic [ACC_W-1:0]    NOM_INC   = ACC_W'(NOMINAL_INC);

  typedef enum logic [1:0] {ACQUIRE, TRACK, HOLDOVER} trackState_t;

  trackState_t             state;
  logic [ACC_W-1:0]        acc, inc, accNext, incNext;
  logic [DIV_W-1:0]        divCnt;
  logic signed [ACC_W-1:0] integ, integNext;
  logic                    s1, s2, s3, aligned, locked, holdover;
  logic [LC_W-1:0]         lockCnt, lockNext;
  logic [1:0]              missCnt;
  logic                    refEdge, carry, wrap, inTol;
  logic signed [PH_W-1:0]  phErr;
  logic signed [W-1:0]     errWide, integSum, integSat, incSum, absErr;

  always_comb begin
    refEdge          = s2 & ~s3;
    {carry, accNext} = {1'b0, acc} + {1'b0, inc};
    wrap             = carry & (&divCnt);
    phErr            = -$signed({divCnt, acc});
    errWide          = W'(phErr);

    integSum = W'(integ) + (errWide >>> KI_SHIFT);
    integSat = integSum;
    if (integSum > INTEG_LIM)       integSat = INTEG_LIM;
    else if (integSum < -INTEG_LIM) integSat = -INTEG_LIM;
    integNext = integSat[ACC_W-1:0];

    incSum  = NOM_W + integSat + (errWide >>> KP_SHIFT);
    incNext = incSum[ACC_W-1:0];
    if (incSum > INC_MAX)      incNext = INC_MAX[ACC_W-1:0];
    else if (incSum < INC_MIN) incNext = INC_MIN[ACC_W-1:0];

    absErr   = errWide[W-1] ? -errWide : errWide;
    inTol    = (absErr <= TOL_W);
    lockNext = '0;
    if (inTol) lockNext = (lockCnt == LOCK_FULL) ? lockCnt : lockCnt + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc      <= '0;
      divCnt   <= '0;
      integ    <= '0;
      inc      <= NOM_INC;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      aligned  <= 1'b0;
      lockCnt  <= '0;
      missCnt  <= '0;
      state    <= ACQUIRE;
      locked   <= 1'b0;
      holdover <= 1'b0;
    end else begin
      s1  <= bus.RefIn;
      s2  <= s1;
      s3  <= s2;
      acc <= accNext;
      if (carry) divCnt <= divCnt + 1'b1;

      if (refEdge) begin
        missCnt <= '0;
        if (!aligned) begin
          // The edge cycle itself is phase zero, so its increment still lands.
          acc      <= inc;
          divCnt   <= '0;
          aligned  <= 1'b1;
          state    <= ACQUIRE;
          locked   <= 1'b0;
          holdover <= 1'b0;
        end else begin
          if (!bus.Hold) begin
            integ <= integNext;
            inc   <= incNext;
          end
          lockCnt <= lockNext;
          if (state == ACQUIRE && lockNext == LOCK_FULL) begin
            state  <= TRACK;
            locked <= 1'b1;
          end else if (state == TRACK && !inTol) begin
            state  <= ACQUIRE;
            locked <= 1'b0;
          end
        end
      end else if (wrap) begin
        if (missCnt != 2'd2) missCnt <= missCnt + 2'd1;
        if (missCnt == 2'd1) begin
          if (state == ACQUIRE) begin
            integ   <= '0;
            inc     <= NOM_INC;
            aligned <= 1'b0;
          end else if (state == TRACK) begin
            state    <= HOLDOVER;
            locked   <= 1'b0;
            holdover <= 1'b1;
            aligned  <= 1'b0;
            lockCnt  <= '0;
          end
        end
      end
    end
  end

  assign bus.ClockOut = acc[ACC_W-1];
  assign bus.CarryOut = divCnt[DIV_W-1];
  assign bus.Locked   = locked;
  assign bus.Holdover = holdover;
  assign bus.FreqWord = inc;
endmodule

// File: tb/tb_dpll_nco_tracker.sv
// Bench for dpll_nco_tracker: directed scenarios plus random reference periods,
// every cycle compared with an integer phase model of the tracker.
module tb_dpll_nco_tracker;
  localparam int ACC_W     = 16;
  localparam int MULT      = 32;
  localparam int NOM       = 2048;
  localparam int PH_MOD    = 1 << 21;
  localparam int HALF      = 1 << 20;
  localparam int INTEG_LIM = 1 << 14;
  localparam int INC_MAX   = 32767;
  localparam int TOL       = 4096;
  localparam int LOCK_N    = 8;

  logic PLLClockStim = 1'b0;
  logic rst = 1'b1;

  dpll_nco_tracker_if #(.ACC_W(ACC_W)) bus ();

  dpll_nco_tracker #(
    .ACC_W(ACC_W), .MULT(MULT), .NOMINAL_INC(NOM), .KP_SHIFT(2),
    .KI_SHIFT(6), .LOCK_TOL(TOL), .LOCK_COUNT(LOCK_N)
  ) dut (
    .Clock(PLLClockStim),
    .Reset(rst),
    .bus  (bus.slave)
  );

  always #5 PLLClockStim = ~PLLClockStim;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkVal(input string tag, input int unsigned observed, input int unsigned expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Model: the NCO is a single phase number modulo MULT*2^ACC_W.
  typedef enum {M_ACQ, M_TRACK, M_HOLD} mState_t;
  int unsigned mPhase;
  int          mInc, mInteg, mLockCnt, mMiss;
  bit          mAligned;
  bit [2:0]    mPipe;
  mState_t     mSt;

  task automatic modelStep(input bit r, input bit h, input bit rs);
    int  e, absE, t;
    bit  edgeNow, wrapNow;
    int unsigned nextPhase;
    if (rs) begin
      mPhase = 0; mInc = NOM; mInteg = 0; mLockCnt = 0; mMiss = 0;
      mAligned = 0; mPipe = '0; mSt = M_ACQ;
      return;
    end
    edgeNow = mPipe[1] && !mPipe[2];
    mPipe   = {mPipe[1:0], r};
    e = -int'(mPhase);
    if (e < -HALF) e += PH_MOD;
    absE      = (e < 0) ? -e : e;
    wrapNow   = (mPhase + mInc) >= PH_MOD;
    nextPhase = (mPhase + mInc) % PH_MOD;
    if (edgeNow) begin
      mMiss = 0;
      if (!mAligned) begin
        nextPhase = mInc;
        mAligned  = 1;
        mSt       = M_ACQ;
      end else begin
        if (!h) begin
          mInteg = mInteg + (e >>> 6);
          if (mInteg > INTEG_LIM) mInteg = INTEG_LIM;
          if (mInteg < -INTEG_LIM) mInteg = -INTEG_LIM;
          t = NOM + mInteg + (e >>> 2);
          if (t > INC_MAX) t = INC_MAX;
          if (t < 1) t = 1;
          mInc = t;
        end
        if (absE <= TOL) mLockCnt = (mLockCnt < LOCK_N) ? mLockCnt + 1 : LOCK_N;
        else mLockCnt = 0;
        if (mSt == M_ACQ && mLockCnt == LOCK_N) mSt = M_TRACK;
        else if (mSt == M_TRACK && absE > TOL) mSt = M_ACQ;
      end
    end else if (wrapNow) begin
      if (mMiss == 1) begin
        if (mSt == M_ACQ) begin
          mInteg = 0; mInc = NOM; mAligned = 0;
        end else if (mSt == M_TRACK) begin
          mSt = M_HOLD; mAligned = 0; mLockCnt = 0;
        end
      end
      if (mMiss < 2) mMiss++;
    end
    mPhase = nextPhase;
  endtask

  task automatic tick();
    @(posedge PLLClockStim);
    modelStep(bus.RefIn, bus.Hold, rst);
    #1;
    checkVal("ClockOut", bus.ClockOut, (mPhase >> 15) & 1);
    checkVal("CarryOut", bus.CarryOut, (mPhase >> 20) & 1);
    checkVal("Locked",   bus.Locked,   (mSt == M_TRACK) ? 1 : 0);
    checkVal("Holdover", bus.Holdover, (mSt == M_HOLD) ? 1 : 0);
    checkVal("FreqWord", bus.FreqWord, mInc);
  endtask

  task automatic refPeriods(input int period, input int count);
    repeat (count) begin
      bus.RefIn = 1'b1;
      repeat (period / 2) tick();
      bus.RefIn = 1'b0;
      repeat (period - period / 2) tick();
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.RefIn = 1'b0;
    bus.Hold  = 1'b0;
    doReset(2);
    refPeriods(1100, 2);

    // mid-run reset
    doReset(3);
    checkVal("rst_ClockOut", bus.ClockOut, 0);
    checkVal("rst_CarryOut", bus.CarryOut, 0);
    checkVal("rst_Locked",   bus.Locked,   0);
    checkVal("rst_Holdover", bus.Holdover, 0);
    checkVal("rst_FreqWord", bus.FreqWord, NOM);

    // nominal reference: lock one cycle after the 9th edge
    refPeriods(1024, 8);
    bus.RefIn = 1'b1;
    tick(); tick();
    checkVal("locked_before_9th", bus.Locked, 0);
    tick();
    checkVal("locked_after_9th", bus.Locked, 1);
    repeat (512 - 3) tick();
    bus.RefIn = 1'b0;
    repeat (512) tick();
    refPeriods(1024, 2);
    checkVal("nominal_freq", bus.FreqWord, NOM);
    checkVal("nominal_locked", bus.Locked, 1);

    // reference loss -> holdover, then relock
    repeat (2300) tick();
    checkVal("holdover_set", bus.Holdover, 1);
    checkVal("holdover_unlocked", bus.Locked, 0);
    checkVal("holdover_freq", bus.FreqWord, NOM);
    refPeriods(1024, 10);
    checkVal("relock", bus.Locked, 1);
    checkVal("relock_holdover", bus.Holdover, 0);

    // Hold freezes FreqWord; lock drops on out-of-tolerance edge
    bus.Hold = 1'b1;
    refPeriods(1024, 1);
    refPeriods(1100, 3);
    checkVal("hold_freq", bus.FreqWord, NOM);
    checkVal("hold_unlocked", bus.Locked, 0);
    bus.Hold = 1'b0;

    // edge coincident with DivCnt wrap
    doReset(1);
    refPeriods(1023, 1);
    refPeriods(1024, 3);

    // large steps hit both Inc clamps
    doReset(1);
    refPeriods(1600, 1);
    bus.RefIn = 1'b1;
    repeat (3) tick();
    checkVal("clamp_high", bus.FreqWord, INC_MAX);
    repeat (800 - 3) tick();
    bus.RefIn = 1'b0;
    repeat (800) tick();

    doReset(1);
    refPeriods(400, 1);
    bus.RefIn = 1'b1;
    repeat (3) tick();
    checkVal("clamp_low", bus.FreqWord, 1);
    repeat (200 - 3) tick();
    bus.RefIn = 1'b0;
    repeat (200) tick();

    // randomized segments
    for (int seg = 0; seg < 10; seg++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        doReset($urandom_range(1, 3));
      end else if (sel == 1) begin
        bus.RefIn = 1'b0;
        repeat ($urandom_range(2100, 2600)) tick();
      end else begin
        bus.Hold = ($urandom_range(0, 3) == 0);
        refPeriods($urandom_range(900, 1150), $urandom_range(1, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
